conv2_weight_rx: RTL and testbench



---
 rtl/conv2_pkg.sv | 18 +
 rtl/conv2_wrx_bank.sv | 48 ++++
 rtl/conv2_weight_rx.sv | 137 +++++++++++++
 tb/tb_conv2_weight_rx.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv2_pkg.sv
// rtl/conv2_pkg.sv - shared parameters and types for the conv2 weight receive path
package conv2_pkg;

    localparam int WEIGHT_W = 8;
    localparam int KSIZE    = 3;
    localparam int IN_CH    = 4;
    localparam int OUT_CH   = 16;
    localparam int FILT_W   = WEIGHT_W * IN_CH * KSIZE;

    typedef logic signed [WEIGHT_W-1:0] weight_t;

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        LOADED
    } wrx_state_t;

endpackage

// File: rtl/conv2_wrx_bank.sv
// rtl/conv2_wrx_bank.sv - conv2 weight register bank with per-tap writes and a registered filter read
module conv2_wrx_bank import conv2_pkg::*; #(
    parameter int WEIGHT_W = conv2_pkg::WEIGHT_W,
    parameter int KSIZE    = conv2_pkg::KSIZE,
    parameter int IN_CH    = conv2_pkg::IN_CH,
    parameter int OUT_CH   = conv2_pkg::OUT_CH
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [KSIZE-1:0]                   tap_we,
    input  logic [IN_CH*OUT_CH*WEIGHT_W-1:0]   wr_bus,
    input  logic                               rd_fire,
    input  logic [$clog2(OUT_CH)-1:0]          rd_filter,
    output logic                               rd_valid,
    output logic [WEIGHT_W*IN_CH*KSIZE-1:0]    rd_data
);

    localparam int DATA_W = WEIGHT_W * IN_CH * KSIZE;

    // Each entry is stored already in read order (c*KSIZE + k), so the read is a plain mux.
    logic [DATA_W-1:0] bank [OUT_CH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int f = 0; f < OUT_CH; f++) begin
                bank[f] <= '0;
            end
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            for (int f = 0; f < OUT_CH; f++) begin
                for (int c = 0; c < IN_CH; c++) begin
                    for (int k = 0; k < KSIZE; k++) begin
                        if (tap_we[k]) begin
                            bank[f][(c*KSIZE+k)*WEIGHT_W +: WEIGHT_W] <=
                                wr_bus[(c*OUT_CH+f)*WEIGHT_W +: WEIGHT_W];
                        end
                    end
                end
            end
            rd_valid <= rd_fire;
            if (rd_fire) begin
                rd_data <= bank[rd_filter];
            end
        end
    end

endmodule

// File: rtl/conv2_weight_rx.sv
// rtl/conv2_weight_rx.sv - conv2 weight broadcast receiver; CONV2_WRX_ZERO_FLAG_EN adds zero_mask
module conv2_weight_rx import conv2_pkg::*; #(
    parameter int WEIGHT_W = conv2_pkg::WEIGHT_W,
    parameter int KSIZE    = conv2_pkg::KSIZE,
    parameter int IN_CH    = conv2_pkg::IN_CH,
    parameter int OUT_CH   = conv2_pkg::OUT_CH
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            clear,
    input  logic                            c2_w_en,
    input  logic [WEIGHT_W*OUT_CH-1:0]      c2_w0,
    input  logic [WEIGHT_W*OUT_CH-1:0]      c2_w1,
    input  logic [WEIGHT_W*OUT_CH-1:0]      c2_w2,
    input  logic [WEIGHT_W*OUT_CH-1:0]      c2_w3,
    output logic                            w_loaded,
    input  logic                            rd_en,
    input  logic [$clog2(OUT_CH)-1:0]       rd_filter,
    output logic                            rd_valid,
    output logic [WEIGHT_W*IN_CH*KSIZE-1:0] rd_data,
`ifdef CONV2_WRX_ZERO_FLAG_EN
    output logic [OUT_CH-1:0]               zero_mask,
`endif
    output logic                            beat_err
);

    wrx_state_t                   state, state_nxt;
    logic [1:0]                   beat, beat_nxt;
    logic                         en_d;
    logic                         beat_err_nxt;
    logic [KSIZE-1:0]             tap_we;
    logic [IN_CH*WEIGHT_W*OUT_CH-1:0] wr_bus;
    logic                         rd_fire;

    assign wr_bus   = {c2_w3, c2_w2, c2_w1, c2_w0};
    assign w_loaded = (state == LOADED);
    assign rd_fire  = rd_en && w_loaded && !clear;

    // The loader's data lags its strobe by one cycle, so capture is keyed off en_d.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            beat     <= 2'd0;
            en_d     <= 1'b0;
            beat_err <= 1'b0;
        end else begin
            state    <= state_nxt;
            beat     <= beat_nxt;
            en_d     <= clear ? 1'b0 : c2_w_en;
            beat_err <= beat_err_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        beat_nxt     = beat;
        beat_err_nxt = beat_err;
        tap_we       = '0;
        if (clear) begin
            state_nxt    = IDLE;
            beat_nxt     = 2'd0;
            beat_err_nxt = 1'b0;
        end else if (en_d) begin
            case (state)
                IDLE: begin
                    tap_we[0] = 1'b1;
                    beat_nxt  = 2'd1;
                    state_nxt = CAPTURE;
                end
                CAPTURE: begin
                    tap_we[beat] = 1'b1;
                    if (beat == 2'(KSIZE-1)) begin
                        beat_nxt  = 2'd0;
                        state_nxt = LOADED;
                    end else begin
                        beat_nxt = beat + 2'd1;
                    end
                end
                LOADED: begin
                    beat_err_nxt = 1'b1;
                end
                default: begin
                    state_nxt = IDLE;
                    beat_nxt  = 2'd0;
                end
            endcase
        end
    end

    conv2_wrx_bank #(
        .WEIGHT_W (WEIGHT_W),
        .KSIZE    (KSIZE),
        .IN_CH    (IN_CH),
        .OUT_CH   (OUT_CH)
    ) u_bank (
        .clk       (clk),
        .rst_n     (rst_n),
        .tap_we    (tap_we),
        .wr_bus    (wr_bus),
        .rd_fire   (rd_fire),
        .rd_filter (rd_filter),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data)
    );

`ifdef CONV2_WRX_ZERO_FLAG_EN
    logic [OUT_CH-1:0] beat_zero;
    logic [OUT_CH-1:0] zero_acc;

    always_comb begin
        beat_zero = '1;
        for (int f = 0; f < OUT_CH; f++) begin
            for (int c = 0; c < IN_CH; c++) begin
                if (wr_bus[(c*OUT_CH+f)*WEIGHT_W +: WEIGHT_W] != '0) begin
                    beat_zero[f] = 1'b0;
                end
            end
        end
    end

    // Beat 0 seeds the accumulator so stale flags from a previous load never leak in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_acc <= '0;
        end else if (clear) begin
            zero_acc <= '0;
        end else if (tap_we[0]) begin
            zero_acc <= beat_zero;
        end else if (|tap_we) begin
            zero_acc <= zero_acc & beat_zero;
        end
    end

    assign zero_mask = w_loaded ? zero_acc : '0;
`endif

endmodule

// File: tb/tb_conv2_weight_rx.sv
// tb/tb_conv2_weight_rx.sv - self-checking bench for conv2_weight_rx
module tb_conv2_weight_rx;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         clear;
    logic         c2_w_en;
    logic [127:0] c2_w0, c2_w1, c2_w2, c2_w3;
    logic         w_loaded;
    logic         rd_en;
    logic [3:0]   rd_filter;
    logic         rd_valid;
    logic [95:0]  rd_data;
    logic         beat_err;
`ifdef CONV2_WRX_ZERO_FLAG_EN
    logic [15:0]  zero_mask;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    logic [95:0] exp_q[$];
    logic [7:0]  mdl [16][4][3];

    conv2_weight_rx dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .c2_w_en   (c2_w_en),
        .c2_w0     (c2_w0),
        .c2_w1     (c2_w1),
        .c2_w2     (c2_w2),
        .c2_w3     (c2_w3),
        .w_loaded  (w_loaded),
        .rd_en     (rd_en),
        .rd_filter (rd_filter),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
`ifdef CONV2_WRX_ZERO_FLAG_EN
        .zero_mask (zero_mask),
`endif
        .beat_err  (beat_err)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] wval(input int f, input int c, input int k,
                                        input logic [7:0] xr, input logic [15:0] zm);
        if (zm[f]) return 8'h00;
        return 8'(f*12 + c*3 + k) ^ xr;
    endfunction

    function automatic logic [95:0] filt_exp(input int f);
        logic [95:0] r;
        r = '0;
        for (int c = 0; c < 4; c++)
            for (int k = 0; k < 3; k++)
                r[(c*3+k)*8 +: 8] = mdl[f][c][k];
        return r;
    endfunction

    function automatic logic [95:0] ramp(input int base);
        logic [95:0] r;
        for (int i = 0; i < 12; i++) r[i*8 +: 8] = 8'(base + i);
        return r;
    endfunction

    task automatic set_bus(input int k, input logic [7:0] xr, input logic [15:0] zm);
        logic [127:0] b [4];
        for (int c = 0; c < 4; c++)
            for (int f = 0; f < 16; f++)
                b[c][f*8 +: 8] = wval(f, c, k, xr, zm);
        c2_w0 = b[0]; c2_w1 = b[1]; c2_w2 = b[2]; c2_w3 = b[3];
    endtask

    task automatic junk_bus;
        c2_w0 = {$urandom, $urandom, $urandom, $urandom};
        c2_w1 = {$urandom, $urandom, $urandom, $urandom};
        c2_w2 = {$urandom, $urandom, $urandom, $urandom};
        c2_w3 = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic pulse_clear;
        clear = 1'b1;
        tick;
        clear = 1'b0;
    endtask

    // Three strobes spaced gap+1 cycles apart; data follows each strobe by one cycle.
    task automatic load_weights(input int gap, input logic [7:0] xr, input logic [15:0] zm);
        int s2;
        s2 = 2 * (gap + 1);
        for (int cyc = 0; cyc < s2 + 2; cyc++) begin
            c2_w_en = (cyc <= s2) && ((cyc % (gap + 1)) == 0);
            if (cyc >= 1 && (cyc - 1) <= s2 && ((cyc - 1) % (gap + 1)) == 0)
                set_bus((cyc - 1) / (gap + 1), xr, zm);
            else
                junk_bus();
            tick;
            if (cyc == s2) begin
                n_checks++;
                if (w_loaded !== 1'b0) begin
                    $display("FAIL load_early gap=%0d: w_loaded=%b expected 0", gap, w_loaded);
                    n_fail++;
                end
            end
        end
        c2_w_en = 1'b0;
        n_checks++;
        if (w_loaded !== 1'b1) begin
            $display("FAIL load_done gap=%0d: w_loaded=%b expected 1", gap, w_loaded);
            n_fail++;
        end
        for (int f = 0; f < 16; f++)
            for (int c = 0; c < 4; c++)
                for (int k = 0; k < 3; k++)
                    mdl[f][c][k] = wval(f, c, k, xr, zm);
    endtask

    task automatic read_check(input int f, input string name);
        logic [95:0] e;
        rd_en = 1'b1;
        rd_filter = 4'(f);
        exp_q.push_back(filt_exp(f));
        tick;
        rd_en = 1'b0;
        e = exp_q.pop_front();
        n_checks++;
        if (rd_valid !== 1'b1) begin
            $display("FAIL %s rd_valid: got %b expected 1", name, rd_valid);
            n_fail++;
        end
        n_checks++;
        if (rd_data !== e) begin
            $display("FAIL %s rd_data f=%0d: got %h expected %h", name, f, rd_data, e);
            n_fail++;
        end
    endtask

    task automatic read_ignored(input string name);
        rd_en = 1'b1;
        rd_filter = 4'd2;
        tick;
        rd_en = 1'b0;
        n_checks++;
        if (rd_valid !== 1'b0) begin
            $display("FAIL %s: rd_valid=%b expected 0", name, rd_valid);
            n_fail++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; clear = 1'b0; c2_w_en = 1'b0; rd_en = 1'b0; rd_filter = 4'd0;
        c2_w0 = '0; c2_w1 = '0; c2_w2 = '0; c2_w3 = '0;
        for (int f = 0; f < 16; f++)
            for (int c = 0; c < 4; c++)
                for (int k = 0; k < 3; k++) mdl[f][c][k] = 8'h00;
        repeat (3) tick;
        n_checks++;
        if ({w_loaded, rd_valid, beat_err} !== 3'b000) begin
            $display("FAIL reset_flags: w_loaded/rd_valid/beat_err=%b expected 000",
                     {w_loaded, rd_valid, beat_err});
            n_fail++;
        end
        n_checks++;
        if (rd_data !== 96'h0) begin
            $display("FAIL reset_rd_data: got %h expected 0", rd_data);
            n_fail++;
        end
        rst_n = 1'b1;
        tick;
        read_ignored("reset_read_idle");
    endtask

    task automatic test_load_consecutive;
        load_weights(0, 8'h00, 16'h0000);
        read_check(5, "consec_f5");
        n_checks++;
        if (rd_data !== ramp(60)) begin
            $display("FAIL consec_bytes: got %h expected %h", rd_data, ramp(60));
            n_fail++;
        end
    endtask

    task automatic test_load_gaps;
        pulse_clear();
        load_weights(2, 8'h00, 16'h0000);
        read_check(15, "gaps_f15");
        n_checks++;
        if (rd_data !== ramp(180)) begin
            $display("FAIL gaps_bytes: got %h expected %h", rd_data, ramp(180));
            n_fail++;
        end
    endtask

    task automatic test_beat_err;
        c2_w_en = 1'b1;
        junk_bus();
        tick;
        c2_w_en = 1'b0;
        n_checks++;
        if (beat_err !== 1'b0) begin
            $display("FAIL beat_err_early: got %b expected 0", beat_err);
            n_fail++;
        end
        junk_bus();
        tick;
        n_checks++;
        if (beat_err !== 1'b1 || w_loaded !== 1'b1) begin
            $display("FAIL beat_err_set: beat_err=%b w_loaded=%b expected 1 1", beat_err, w_loaded);
            n_fail++;
        end
        read_check(0, "beat_err_f0");
        n_checks++;
        if (rd_data !== ramp(0)) begin
            $display("FAIL beat_err_bytes: got %h expected %h", rd_data, ramp(0));
            n_fail++;
        end
    endtask

    task automatic test_clear;
        rd_en = 1'b1;
        rd_filter = 4'd4;
        clear = 1'b1;
        tick;
        rd_en = 1'b0;
        clear = 1'b0;
        n_checks++;
        if ({rd_valid, w_loaded, beat_err} !== 3'b000) begin
            $display("FAIL clear_rd: rd_valid/w_loaded/beat_err=%b expected 000",
                     {rd_valid, w_loaded, beat_err});
            n_fail++;
        end
        c2_w_en = 1'b1; junk_bus(); tick;
        c2_w_en = 1'b1; set_bus(0, 8'h3C, 16'h0); tick;
        c2_w_en = 1'b0; set_bus(1, 8'h3C, 16'h0); clear = 1'b1; tick;
        clear = 1'b0;
        junk_bus();
        n_checks++;
        if (w_loaded !== 1'b0) begin
            $display("FAIL clear_collide: w_loaded=%b expected 0", w_loaded);
            n_fail++;
        end
        read_ignored("clear_read");
        load_weights(0, 8'h3C, 16'h0000);
        read_check(7, "clear_reload_f7");
    endtask

    task automatic test_reset_mid;
        pulse_clear();
        c2_w_en = 1'b1; junk_bus(); tick;
        c2_w_en = 1'b1; set_bus(0, 8'h5A, 16'h0); tick;
        c2_w_en = 1'b0; set_bus(1, 8'h5A, 16'h0); tick;
        rst_n = 1'b0;
        tick;
        n_checks++;
        if ({w_loaded, rd_valid, beat_err} !== 3'b000 || rd_data !== 96'h0) begin
            $display("FAIL reset_mid_outputs: flags=%b rd_data=%h expected 000 and 0",
                     {w_loaded, rd_valid, beat_err}, rd_data);
            n_fail++;
        end
        for (int f = 0; f < 16; f++)
            for (int c = 0; c < 4; c++)
                for (int k = 0; k < 3; k++) mdl[f][c][k] = 8'h00;
        rst_n = 1'b1;
        tick;
        read_ignored("reset_mid_read");
        c2_w_en = 1'b1; junk_bus(); tick;
        c2_w_en = 1'b0; set_bus(2, 8'h5A, 16'h0); tick;
        tick;
        n_checks++;
        if (w_loaded !== 1'b0) begin
            $display("FAIL reset_mid_partial: w_loaded=%b expected 0", w_loaded);
            n_fail++;
        end
        read_ignored("reset_mid_partial_read");
        pulse_clear();
        load_weights(1, 8'h5A, 16'h0000);
        read_check(11, "reset_mid_f11");
    endtask

    task automatic test_back_to_back;
        logic [95:0] last;
        for (int i = 0; i < 20; i++) begin
            int f;
            f = (i < 16) ? (15 - i) : int'($urandom_range(0, 15));
            rd_en = 1'b1;
            rd_filter = 4'(f);
            exp_q.push_back(filt_exp(f));
            tick;
            last = exp_q.pop_front();
            n_checks++;
            if (rd_valid !== 1'b1 || rd_data !== last) begin
                $display("FAIL b2b_%0d f=%0d: valid=%b data=%h expected 1 %h", i, f, rd_valid, rd_data, last);
                n_fail++;
            end
        end
        rd_en = 1'b0;
        rd_filter = 4'd0;
        tick;
        n_checks++;
        if (rd_valid !== 1'b0 || rd_data !== last) begin
            $display("FAIL b2b_hold: valid=%b data=%h expected 0 %h", rd_valid, rd_data, last);
            n_fail++;
        end
    endtask

`ifdef CONV2_WRX_ZERO_FLAG_EN
    task automatic test_zero_flag;
        pulse_clear();
        n_checks++;
        if (zero_mask !== 16'h0000) begin
            $display("FAIL zero_after_clear: got %h expected 0000", zero_mask);
            n_fail++;
        end
        load_weights(0, 8'h00, 16'h0208);
        n_checks++;
        if (zero_mask !== 16'h0208) begin
            $display("FAIL zero_mask: got %h expected 0208", zero_mask);
            n_fail++;
        end
        read_check(9, "zero_f9");
    endtask
`endif

    initial begin
        test_reset();
        test_load_consecutive();
        test_load_gaps();
        test_beat_err();
        test_clear();
        test_reset_mid();
        test_back_to_back();
`ifdef CONV2_WRX_ZERO_FLAG_EN
        test_zero_flag();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
